// File: rtl/pacman_pkg.sv
// Shared types and constants for the Pac-Man sprite logic.
//   dir_t        : heading encoding shared by the player and ghost movers
//   move_state_t : player movement FSM states
//   SCREEN_*     : visible area in pixels
package pacman_pkg;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MOVE = 2'd1,
        ST_STOP = 2'd2
    } move_state_t;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

endpackage

// File: rtl/key_dir_encoder.sv
// Combinational priority encoder from four direction keys to a heading.
// Priority is Up > Down > Left > Right.
//   key_up/key_down/key_left/key_right : level key inputs
//   valid                              : at least one key is pressed
//   dir                                : highest-priority pressed key (RIGHT when none)
module key_dir_encoder
    import pacman_pkg::*;
(
    input  logic key_up,
    input  logic key_down,
    input  logic key_left,
    input  logic key_right,
    output logic valid,
    output dir_t dir
);

    always_comb begin
        valid = key_up | key_down | key_left | key_right;
        dir   = DIR_RIGHT;
        if (key_up) begin
            dir = DIR_UP;
        end else if (key_down) begin
            dir = DIR_DOWN;
        end else if (key_left) begin
            dir = DIR_LEFT;
        end
    end

endmodule

// File: rtl/pacman_move.sv
// Per-frame movement controller for the Pac-Man sprite.
// Buffers the requested heading, steps the sprite once per frame, backs off and stops on a
// wall collision, wraps horizontally through the tunnel and clamps vertically.
//   clk, resetN                     : clock, asynchronous active-low reset
//   startOfFrame                    : one-cycle pulse between frames
//   keyUp/keyDown/keyLeft/keyRight  : level key inputs
//   collision                       : sprite overlaps a wall pixel (any cycle of the frame)
//   pause                           : freeze motion while high
//   topLeftX/topLeftY               : signed sprite position
//   direction                       : current heading (0=R 1=L 2=U 3=D)
//   moving                          : high while in ST_MOVE
module pacman_move #(
    parameter int INITIAL_X     = 304,
    parameter int INITIAL_Y     = 352,
    parameter int SPEED         = 2,
    parameter int OBJECT_WIDTH  = 32,
    parameter int OBJECT_HEIGHT = 32,
    parameter int SCREEN_WIDTH  = pacman_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT = pacman_pkg::SCREEN_HEIGHT
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               keyUp,
    input  logic               keyDown,
    input  logic               keyLeft,
    input  logic               keyRight,
    input  logic               collision,
    input  logic               pause,
    output logic signed [10:0] topLeftX,
    output logic signed [10:0] topLeftY,
    output logic [1:0]         direction,
    output logic               moving
);

    import pacman_pkg::*;

    localparam logic signed [12:0] SPD     = 13'(SPEED);
    localparam logic signed [12:0] X_MAX   = 13'(SCREEN_WIDTH - 1);
    localparam logic signed [12:0] X_MIN   = 13'(1 - OBJECT_WIDTH);
    localparam logic signed [12:0] Y_MAX   = 13'(SCREEN_HEIGHT - OBJECT_HEIGHT);
    localparam logic signed [10:0] X_MAX11 = 11'(SCREEN_WIDTH - 1);
    localparam logic signed [10:0] X_MIN11 = 11'(1 - OBJECT_WIDTH);
    localparam logic signed [10:0] Y_MAX11 = 11'(SCREEN_HEIGHT - OBJECT_HEIGHT);

    move_state_t        state_q, state_d;
    dir_t               dir_q, dir_d;
    dir_t               pending_dir_q, pending_dir_d;
    logic               pending_valid_q, pending_valid_d;
    dir_t               blocked_dir_q, blocked_dir_d;
    logic               blocked_valid_q, blocked_valid_d;
    logic               coll_latch_q, coll_latch_d;
    logic signed [10:0] x_q, x_d;
    logic signed [10:0] y_q, y_d;

    logic               key_valid;
    dir_t               key_dir;

    key_dir_encoder u_key_dir_encoder (
        .key_up    (keyUp),
        .key_down  (keyDown),
        .key_left  (keyLeft),
        .key_right (keyRight),
        .valid     (key_valid),
        .dir       (key_dir)
    );

    // A collision arriving together with startOfFrame belongs to the frame that is ending.
    logic coll_flag;
    logic frame_act;
    logic retreat;
    dir_t step_dir;

    assign coll_flag = coll_latch_q | collision;
    assign frame_act = startOfFrame & ~pause;
    assign retreat   = (state_q == ST_MOVE) & coll_flag;

    // Heading used by the arithmetic: the retreat and an un-redirected move use the current
    // heading, every other step takes the buffered request.
    always_comb begin
        step_dir = dir_q;
        if (state_q != ST_MOVE || (!coll_flag && pending_valid_q)) begin
            step_dir = pending_dir_q;
        end
    end

    // Step, tunnel wrap and vertical clamp in 13-bit signed space.
    logic signed [12:0] dx, dy, sum_x, sum_y;
    logic signed [10:0] new_x, new_y;
    logic               clamp_hit;

    always_comb begin
        dx = '0;
        dy = '0;
        unique case (step_dir)
            DIR_RIGHT: dx = SPD;
            DIR_LEFT:  dx = -SPD;
            DIR_UP:    dy = -SPD;
            DIR_DOWN:  dy = SPD;
            default:   dx = '0;
        endcase
        if (retreat) begin
            dx = -dx;
            dy = -dy;
        end
        sum_x = {{2{x_q[10]}}, x_q} + dx;
        sum_y = {{2{y_q[10]}}, y_q} + dy;

        if (sum_x > X_MAX) begin
            new_x = X_MIN11;
        end else if (sum_x < X_MIN) begin
            new_x = X_MAX11;
        end else begin
            new_x = sum_x[10:0];
        end

        clamp_hit = 1'b0;
        if (sum_y < 13'sd0) begin
            new_y     = '0;
            clamp_hit = 1'b1;
        end else if (sum_y > Y_MAX) begin
            new_y     = Y_MAX11;
            clamp_hit = 1'b1;
        end else begin
            new_y = sum_y[10:0];
        end
    end

    logic do_step;

    always_comb begin
        state_d         = state_q;
        dir_d           = dir_q;
        x_d             = x_q;
        y_d             = y_q;
        blocked_dir_d   = blocked_dir_q;
        blocked_valid_d = blocked_valid_q;
        coll_latch_d    = coll_latch_q | collision;
        pending_dir_d   = key_valid ? key_dir : pending_dir_q;
        pending_valid_d = pending_valid_q | key_valid;
        do_step         = 1'b0;

        if (frame_act) begin
            coll_latch_d = 1'b0;
            unique case (state_q)
                ST_IDLE: do_step = pending_valid_q;
                ST_MOVE: begin
                    if (coll_flag) begin
                        x_d             = new_x;
                        y_d             = new_y;
                        blocked_dir_d   = dir_q;
                        blocked_valid_d = 1'b1;
                        state_d         = ST_STOP;
                    end else begin
                        do_step = 1'b1;
                    end
                end
                ST_STOP: begin
                    // The flag here was raised by the retreat itself, so it is ignored.
                    if (pending_valid_q &&
                        !(blocked_valid_q && pending_dir_q == blocked_dir_q)) begin
                        blocked_valid_d = 1'b0;
                        do_step         = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase

            if (do_step) begin
                dir_d = step_dir;
                x_d   = new_x;
                y_d   = new_y;
                // A clamped step already sits against the edge: stop without backing off.
                if (clamp_hit) begin
                    state_d         = ST_STOP;
                    blocked_dir_d   = step_dir;
                    blocked_valid_d = 1'b1;
                end else begin
                    state_d = ST_MOVE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q         <= ST_IDLE;
            dir_q           <= DIR_RIGHT;
            pending_dir_q   <= DIR_RIGHT;
            pending_valid_q <= 1'b0;
            blocked_dir_q   <= DIR_RIGHT;
            blocked_valid_q <= 1'b0;
            coll_latch_q    <= 1'b0;
            x_q             <= 11'(INITIAL_X);
            y_q             <= 11'(INITIAL_Y);
        end else begin
            state_q         <= state_d;
            dir_q           <= dir_d;
            pending_dir_q   <= pending_dir_d;
            pending_valid_q <= pending_valid_d;
            blocked_dir_q   <= blocked_dir_d;
            blocked_valid_q <= blocked_valid_d;
            coll_latch_q    <= coll_latch_d;
            x_q             <= x_d;
            y_q             <= y_d;
        end
    end

    assign topLeftX  = x_q;
    assign topLeftY  = y_q;
    assign direction = dir_q;
    assign moving    = (state_q == ST_MOVE);

endmodule

// File: doc/pacman_move.md
Name: pacman_move

Overview:
Per-frame movement controller for the Pac-Man sprite.
- Produces the signed topLeftX/topLeftY position that the square-object/bitmap stage uses for bracket and offset calculation.
- Buffers the player's requested direction and steps the position once per frame.
- Retreats and stops on a wall collision reported by the drawing pipeline, and wraps horizontally through the tunnel.

Parameters:
INITIAL_X, 304, reset X position (pixels)
INITIAL_Y, 352, reset Y position (pixels)
SPEED, 2, pixels moved per frame (1..8)
OBJECT_WIDTH, 32, sprite width (pixels)
OBJECT_HEIGHT, 32, sprite height (pixels)
SCREEN_WIDTH, 640, visible width
SCREEN_HEIGHT, 480, visible height

Ports:
clk  in  1  system clock
resetN  in  1  reset, asynchronous, active-low
startOfFrame  in  1  one-cycle pulse per frame, between frames
keyUp/keyDown/keyLeft/keyRight  in  1 each  level key inputs
collision  in  1  Pac-Man pixel overlaps wall pixel, any cycle of the frame
pause  in  1  freeze motion while high
topLeftX  out  11 signed  sprite X position
topLeftY  out  11 signed  sprite Y position
direction  out  2  current heading: 0=RIGHT 1=LEFT 2=UP 3=DOWN
moving  out  1  high in ST_MOVE

Behaviour:
Reset values:
- topLeftX=INITIAL_X, topLeftY=INITIAL_Y, direction=RIGHT, moving=0.
- State ST_IDLE; pendingValid=0; blockedValid=0; collLatch=0.

Key buffer (every cycle, including during pause):
- Any key high → pendingDir = priority-encoded key (Up>Down>Left>Right), pendingValid=1.
- No key → pending unchanged (sticky).

Collision latch:
- collLatch set on any cycle with collision=1.
- Cleared on a startOfFrame that is acted on (pause=0).
- Effective flag at a frame = collLatch | collision. A collision in the same cycle as startOfFrame belongs to the ending frame.

Frame update (startOfFrame=1, pause=0); outputs registered, visible the cycle after the pulse:
- ST_IDLE:
  - pendingValid → direction=pendingDir, go ST_MOVE, apply one step this frame.
  - Otherwise stay.
- ST_MOVE, effective flag=1:
  - Undo the last step (position -= SPEED along direction, same wrap rules).
  - blockedDir=direction, blockedValid=1, go ST_STOP. No forward step this frame.
- ST_MOVE, flag=0:
  - If pendingValid, direction=pendingDir.
  - Step SPEED along direction.
- ST_STOP:
  - Collision flag ignored (it was caused by the retreat frame).
  - If pendingValid and !(blockedValid && pendingDir==blockedDir): direction=pendingDir, blockedValid=0, step, go ST_MOVE.
  - Otherwise stay; position holds.

Arithmetic (13-bit signed intermediate, result fits 11 bits):
- X wrap:
  - newX > SCREEN_WIDTH-1 → newX = -OBJECT_WIDTH+1.
  - newX < -OBJECT_WIDTH+1 → newX = SCREEN_WIDTH-1.
- Y clamp: newY limited to 0..SCREEN_HEIGHT-OBJECT_HEIGHT. When a clamp limits the move it counts as a collision next frame (go ST_STOP immediately, no undo).

Pause:
- startOfFrame ignored for motion; position, state and collLatch hold.

Reset mid-frame:
- All registers return to reset values asynchronously.
- The first startOfFrame after release is handled from ST_IDLE.

Decomposition:
Package pacman_pkg:
- dir_t enum {DIR_RIGHT=0, DIR_LEFT=1, DIR_UP=2, DIR_DOWN=3}.
- move_state_t enum {ST_IDLE, ST_MOVE, ST_STOP}.
- Shared constants SCREEN_WIDTH=640, SCREEN_HEIGHT=480.

Sub-module key_dir_encoder:
- Combinational priority encoder: four keys → {valid, dir_t}.
- Reused by the ghost/menu logic.

Position update (step, wrap, clamp) and FSM stay in pacman_move.

Test Plan:
1. Reset, no keys, 3 frames → topLeft stays (304,352), direction=0, moving=0.
2. keyRight 1 cycle, then 4 frames → X=306,308,310,312, Y=352, moving=1, each visible the cycle after the pulse.
3. Moving right at X=312; collision pulse mid-frame; next frame:
   - X=310, moving=0.
   - keyRight held 3 frames → X stays 310.
   - keyUp → Y=350 next frame, direction=2.
4. Moving right from X=638 → X=640 wraps to -31.
   - Moving left from X=-30 → -32 wraps to 639.
5. Collision and startOfFrame in the same cycle → treated as collision: undo step, ST_STOP.
   - pause=1 for 5 frames with keyDown pressed → position frozen; after pause=0, next frame Y+=2.
6. resetN low mid-frame while moving at (400,100) → outputs immediately (304,352), dir 0, moving 0.
   - After release, no motion until a key press.
